// File: rtl/excess_3_to_bcd_if.sv
// Serial Excess-3 in / serial+parallel BCD out bus for excess_3_to_bcd.
// The master drives the serial code stream; the slave (the decoder) returns
// the decoded bit stream, the assembled digit and the error status.
interface excess_3_to_bcd_if #(
  parameter int ERR_CNT_W = 4
);
  logic                 B_in;
  logic                 B_en;
  logic                 B_out;
  logic                 B_out_vld;
  logic [3:0]           digit;
  logic                 digit_vld;
  logic                 code_err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [1:0]           bit_idx;

  modport master (
    output B_in, B_en,
    input  B_out, B_out_vld, digit, digit_vld, code_err, err_cnt, bit_idx
  );

  modport slave (
    input  B_in, B_en,
    output B_out, B_out_vld, digit, digit_vld, code_err, err_cnt, bit_idx
  );
endinterface

// File: rtl/excess_3_to_bcd.sv
// Bit-serial Excess-3 to BCD decoder.
// Subtracts 3 from each 4-bit word (LSB first) with a borrow-tracking Mealy
// machine, streams the result bits out one cycle later, and on the last bit
// of each word publishes the parallel digit, a legality flag and a saturating
// count of illegal words. ERR_CNT_W must match the bus interface parameter.
module excess_3_to_bcd #(
  parameter int ERR_CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset_b,
  excess_3_to_bcd_if.slave   bus
);

  typedef enum logic [2:0] {
    S_B0,
    S_B1_NB,
    S_B1_B,
    S_B2_NB,
    S_B2_B,
    S_B3_NB,
    S_B3_B
  } state_t;

  state_t               r_state;
  logic                 r_bOut;
  logic                 r_bOutVld;
  logic [3:0]           r_digit;
  logic                 r_digitVld;
  logic                 r_codeErr;
  logic [ERR_CNT_W-1:0] r_errCnt;
  logic [1:0]           r_bitIdx;
  logic [2:0]           r_outBits;
  logic [2:0]           r_codeBits;

  state_t               w_nextState;
  logic                 w_outBit;
  logic                 w_lastBit;
  logic [3:0]           w_digit;
  logic [3:0]           w_code;
  logic                 w_illegal;

  // Mealy output bit and next state: subtract the constant 0011 one bit at a time
  always_comb begin
    w_nextState = S_B0;
    w_outBit    = 1'b0;
    w_lastBit   = 1'b0;
    case (r_state)
      S_B0: begin
        w_outBit    = ~bus.B_in;
        w_nextState = bus.B_in ? S_B1_NB : S_B1_B;
      end
      S_B1_NB: begin
        w_outBit    = ~bus.B_in;
        w_nextState = bus.B_in ? S_B2_NB : S_B2_B;
      end
      S_B1_B: begin
        w_outBit    = bus.B_in;
        w_nextState = S_B2_B;
      end
      S_B2_NB: begin
        w_outBit    = bus.B_in;
        w_nextState = S_B3_NB;
      end
      S_B2_B: begin
        w_outBit    = ~bus.B_in;
        w_nextState = bus.B_in ? S_B3_NB : S_B3_B;
      end
      S_B3_NB: begin
        w_outBit    = bus.B_in;
        w_lastBit   = 1'b1;
        w_nextState = S_B0;
      end
      S_B3_B: begin
        w_outBit    = ~bus.B_in;
        w_lastBit   = 1'b1;
        w_nextState = S_B0;
      end
      default: begin
        w_outBit    = 1'b0;
        w_nextState = S_B0;
      end
    endcase
  end

  assign w_digit   = {w_outBit, r_outBits};
  assign w_code    = {bus.B_in, r_codeBits};
  assign w_illegal = (w_code < 4'd3) || (w_code > 4'd12);

  // State machine with registered outputs; strobes default low, reset wins over B_en
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_state    <= S_B0;
      r_bOut     <= 1'b0;
      r_bOutVld  <= 1'b0;
      r_digit    <= 4'd0;
      r_digitVld <= 1'b0;
      r_codeErr  <= 1'b0;
      r_errCnt   <= '0;
      r_bitIdx   <= 2'd0;
      r_outBits  <= 3'd0;
      r_codeBits <= 3'd0;
    end else begin
      r_bOutVld  <= 1'b0;
      r_digitVld <= 1'b0;
      if (bus.B_en) begin
        r_state    <= w_nextState;
        r_bOut     <= w_outBit;
        r_bOutVld  <= 1'b1;
        r_bitIdx   <= r_bitIdx + 2'd1;
        r_outBits  <= {w_outBit, r_outBits[2:1]};
        r_codeBits <= {bus.B_in, r_codeBits[2:1]};
        if (w_lastBit) begin
          r_digit    <= w_digit;
          r_digitVld <= 1'b1;
          r_codeErr  <= w_illegal;
          if (w_illegal && (r_errCnt != {ERR_CNT_W{1'b1}})) begin
            r_errCnt <= r_errCnt + 1'b1;
          end
        end
      end
    end
  end

  assign bus.B_out     = r_bOut;
  assign bus.B_out_vld = r_bOutVld;
  assign bus.digit     = r_digit;
  assign bus.digit_vld = r_digitVld;
  assign bus.code_err  = r_codeErr;
  assign bus.err_cnt   = r_errCnt;
  assign bus.bit_idx   = r_bitIdx;

endmodule

// File: tb/tb_excess_3_to_bcd.sv
// Directed testbench for excess_3_to_bcd with a reference model and a
// one-cycle scoreboard of expected output snapshots.
module tb_excess_3_to_bcd;

  localparam int ERR_CNT_W = 4;

  typedef struct {
    logic                 bOut;
    logic                 bOutVld;
    logic [3:0]           digit;
    logic                 digitVld;
    logic                 codeErr;
    logic [ERR_CNT_W-1:0] errCnt;
    logic [1:0]           bitIdx;
  } expect_t;

  logic clk;
  logic reset_b;

  excess_3_to_bcd_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

  excess_3_to_bcd #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  expect_t scoreboard[$];

  int testsRun;
  int testsFailed;

  // Reference model state
  logic                 mBOut;
  logic [3:0]           mDigit;
  logic                 mCodeErr;
  logic [ERR_CNT_W-1:0] mErrCnt;
  logic [1:0]           mBitIdx;
  logic [3:0]           mCode;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and push the model's prediction for the next edge
  task automatic applyStimulus(input logic rstB, input logic en, input logic bin);
    expect_t e;
    int      low;
    int      diff;
    int      fullCode;
    reset_b    = rstB;
    bus.B_en   = en;
    bus.B_in   = bin;
    e.bOutVld  = 1'b0;
    e.digitVld = 1'b0;
    if (!rstB) begin
      mBOut    = 1'b0;
      mDigit   = 4'd0;
      mCodeErr = 1'b0;
      mErrCnt  = '0;
      mBitIdx  = 2'd0;
      mCode    = 4'd0;
    end else if (en) begin
      mCode[mBitIdx] = bin;
      low   = int'(mCode) & ((1 << (int'(mBitIdx) + 1)) - 1);
      diff  = low - 3;
      mBOut = diff[mBitIdx];
      e.bOutVld = 1'b1;
      if (mBitIdx == 2'd3) begin
        fullCode   = int'(mCode);
        mDigit     = 4'((fullCode - 3) & 15);
        mCodeErr   = (fullCode < 3) || (fullCode > 12);
        e.digitVld = 1'b1;
        if (mCodeErr && (mErrCnt != {ERR_CNT_W{1'b1}})) mErrCnt = mErrCnt + 1'b1;
      end
      mBitIdx = mBitIdx + 2'd1;
    end
    e.bOut    = mBOut;
    e.digit   = mDigit;
    e.codeErr = mCodeErr;
    e.errCnt  = mErrCnt;
    e.bitIdx  = mBitIdx;
    scoreboard.push_back(e);
  endtask

  // Wait for the edge, then compare every output against the oldest prediction
  task automatic checkOutput(input string tag);
    expect_t e;
    @(posedge clk);
    #1;
    testsRun++;
    assert (scoreboard.size() > 0)
      else begin testsFailed++; $error("[TB] FAIL %s scoreboard: observed empty, expected entry", tag); end
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      testsRun += 7;
      assert (bus.B_out === e.bOut)
        else begin testsFailed++; $error("[TB] FAIL %s B_out: observed %b expected %b", tag, bus.B_out, e.bOut); end
      assert (bus.B_out_vld === e.bOutVld)
        else begin testsFailed++; $error("[TB] FAIL %s B_out_vld: observed %b expected %b", tag, bus.B_out_vld, e.bOutVld); end
      assert (bus.digit === e.digit)
        else begin testsFailed++; $error("[TB] FAIL %s digit: observed %b expected %b", tag, bus.digit, e.digit); end
      assert (bus.digit_vld === e.digitVld)
        else begin testsFailed++; $error("[TB] FAIL %s digit_vld: observed %b expected %b", tag, bus.digit_vld, e.digitVld); end
      assert (bus.code_err === e.codeErr)
        else begin testsFailed++; $error("[TB] FAIL %s code_err: observed %b expected %b", tag, bus.code_err, e.codeErr); end
      assert (bus.err_cnt === e.errCnt)
        else begin testsFailed++; $error("[TB] FAIL %s err_cnt: observed %0d expected %0d", tag, bus.err_cnt, e.errCnt); end
      assert (bus.bit_idx === e.bitIdx)
        else begin testsFailed++; $error("[TB] FAIL %s bit_idx: observed %0d expected %0d", tag, bus.bit_idx, e.bitIdx); end
    end
  endtask

  task automatic stepCycle(input string tag, input logic rstB, input logic en, input logic bin);
    applyStimulus(rstB, en, bin);
    checkOutput(tag);
  endtask

  // One full word, LSB first, back to back
  task automatic sendWord(input string tag, input logic [3:0] code);
    for (int i = 0; i < 4; i++) stepCycle(tag, 1'b1, 1'b1, code[i]);
  endtask

  // Directed sequence
  initial begin
    logic [3:0] code;
    testsRun    = 0;
    testsFailed = 0;
    reset_b     = 1'b0;
    bus.B_en    = 1'b0;
    bus.B_in    = 1'b0;
    #1;

    stepCycle("reset", 1'b0, 1'b0, 1'b0);
    stepCycle("reset_en", 1'b0, 1'b1, 1'b1);

    sendWord("code0011", 4'b0011);
    sendWord("code1100", 4'b1100);
    sendWord("code0000", 4'b0000);
    sendWord("code1111", 4'b1111);
    stepCycle("idle", 1'b1, 1'b0, 1'b1);

    code = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      stepCycle("gap_bit", 1'b1, 1'b1, code[i]);
      if (i < 3) begin
        for (int g = 0; g <= i; g++) stepCycle("gap_idle", 1'b1, 1'b0, ~code[i]);
      end
    end

    code = 4'b1000;
    stepCycle("partial", 1'b1, 1'b1, code[0]);
    stepCycle("partial", 1'b1, 1'b1, code[1]);
    stepCycle("midreset", 1'b0, 1'b1, code[2]);
    sendWord("code0100", 4'b0100);

    for (int k = 0; k < 16; k++) begin
      case (k % 6)
        0:       code = 4'b0000;
        1:       code = 4'b0001;
        2:       code = 4'b0010;
        3:       code = 4'b1101;
        4:       code = 4'b1110;
        default: code = 4'b1111;
      endcase
      sendWord("illegal", code);
    end
    sendWord("code1001", 4'b1001);
    stepCycle("tail", 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/excess_3_to_bcd.md
EXCESS_3_TO_BCD -- requirements
Module: excess_3_to_bcd

Interface
REQ-001 Parameter: ERR_CNT_W, default 4, width of the saturating invalid-code counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_b  input  1  reset, synchronous, active-low.
REQ-004 B_in  input  1  serial Excess-3 code bit, LSB first, 4 bits per digit.
REQ-005 B_en  input  1  bit qualifier; B_in is consumed only on edges where B_en=1.
REQ-006 B_out  output  1  registered serial BCD bit, LSB first.
REQ-007 B_out_vld  output  1  high for one cycle after each consumed bit.
REQ-008 digit  output  4  parallel decoded BCD digit of the last completed word.
REQ-009 digit_vld  output  1  one-cycle pulse when digit updates.
REQ-010 code_err  output  1  last completed word was not a legal Excess-3 code.
REQ-011 err_cnt  output  ERR_CNT_W  count of illegal words, saturating.
REQ-012 bit_idx  output  2  position of the next bit to be consumed (0 = LSB).

Function
REQ-013 Decode rule: digit = (4-bit code - 3) mod 16; legal codes are 0011..1100, giving 0..9.
REQ-014 Serial subtraction by a Mealy-style bit-serial borrow machine with states S_B0, S_B1_NB, S_B1_B, S_B2_NB, S_B2_B, S_B3_NB, S_B3_B (NB = no borrow, B = borrow pending).
REQ-015 S_B0: out = ~B_in; next is S_B1_B if B_in=0, else S_B1_NB.
REQ-016 S_B1_x: out = B_in ^ 1 ^ borrow; borrow_out = ~B_in | borrow; next is S_B2_B or S_B2_NB.
REQ-017 S_B2_x: out = B_in ^ borrow; borrow_out = ~B_in & borrow; next is S_B3_B or S_B3_NB.
REQ-018 S_B3_x: out = B_in ^ borrow; next is S_B0; the final borrow is discarded (mod-16 wrap).
REQ-019 State advances only on edges with B_en=1; with B_en=0 the state, bit_idx, B_out, digit, code_err and err_cnt hold, and B_out_vld and digit_vld are 0.
REQ-020 On each consumed bit, B_out takes the computed bit and B_out_vld=1 on the same edge; latency from B_in sampled to B_out visible is 1 clock.
REQ-021 On the edge consuming the bit-3 input, digit loads the 4 assembled output bits, digit_vld pulses for exactly 1 cycle, and code_err loads (code<3 or code>12).
REQ-022 On that same edge, err_cnt increments by 1 when the code is illegal, and holds at 2^ERR_CNT_W-1 once reached.
REQ-023 code_err and digit hold their values until the next completed word.
REQ-024 Back-to-back words with B_en held at 1 are decoded with no idle cycle; digit_vld pulses every 4th cycle.
REQ-025 bit_idx wraps 3 -> 0 on word completion.

Reset
REQ-026 On an edge with reset_b=0, the state goes to S_B0 and all outputs clear: B_out=0, B_out_vld=0, digit=0, digit_vld=0, code_err=0, err_cnt=0, bit_idx=0.
REQ-027 Reset has priority over B_en.
REQ-028 Reset mid-word discards the partial word with no digit_vld pulse, and the first consumed bit after release is the LSB of a new word.

Verification
REQ-029 Reset, then B_en=1 with B_in=1,1,0,0 (code 0011) -> B_out=0,0,0,0; digit=0; digit_vld 1 pulse; code_err=0.
REQ-030 B_in=0,0,1,1 (code 1100) -> B_out=1,0,0,1; digit=9; code_err=0; err_cnt unchanged.
REQ-031 B_in=0,0,0,0 (code 0000) -> digit=4'b1101; code_err=1; err_cnt=1. Then code 1111 -> digit=4'b1100; err_cnt=2.
REQ-032 Code 0111 delivered with B_en=0 gaps of 1-3 cycles between bits -> B_out_vld only on enabled edges; digit=4 after the 4th enabled bit; nothing changes during gaps.
REQ-033 Two bits of code 1000 consumed, then reset_b=0 for 1 cycle -> outputs 0, bit_idx=0, no digit_vld. Next code 0100 -> digit=1.
REQ-034 Sixteen consecutive illegal codes with ERR_CNT_W=4 -> err_cnt saturates at 15.
